// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator-machine control path:
// instruction opcodes, ALU selects, sequencer states, and SKIPCOND conditions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_AND      = 4'h5;
  localparam logic [3:0] OP_OR       = 4'h6;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  function automatic logic skip_taken(input logic [1:0] cond, input logic [15:0] ac);
    logic taken;
    taken = 1'b0;
    case (cond)
      SKIP_NEG:  taken = ac[15];
      SKIP_ZERO: taken = (ac == 16'h0000);
      SKIP_POS:  taken = !ac[15] && (ac != 16'h0000);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode: post-DECODE state, jump/illegal flags and ALU select.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output state_t     o_next_state,
  output logic       o_is_jump,
  output logic       o_is_illegal,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_next_state = FETCH;
    o_is_jump    = 1'b0;
    o_is_illegal = 1'b0;
    o_alu_op     = 4'b0000;
    case (i_opcode)
      OP_NOP:      o_next_state = FETCH;
      OP_LOAD:     o_next_state = READ;
      OP_STORE:    o_next_state = WRITE;
      OP_ADD:      begin o_next_state = READ; o_alu_op = ALU_ADD; end
      OP_SUB:      begin o_next_state = READ; o_alu_op = ALU_SUB; end
      OP_AND:      begin o_next_state = READ; o_alu_op = ALU_AND; end
      OP_OR:       begin o_next_state = READ; o_alu_op = ALU_OR;  end
      OP_HALT:     o_next_state = HALTED;
      OP_SKIPCOND: o_next_state = EXEC;
      OP_JUMP:     begin o_next_state = FETCH; o_is_jump = 1'b1; end
      default:     begin o_next_state = HALTED; o_is_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle fetch/decode/execute sequencer owning PC, IR and AC; drives
// the synchronous-read main memory and the combinational ALU.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] alu_result,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [11:0] pc_out,
  output logic [15:0] acc_out,
  output logic [15:0] ir_out,
  output logic        halted,
  output logic        illegal
);

  state_t      r_state;
  logic [11:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_ac;
  logic        r_illegal;

  logic [3:0]  w_dec_opcode;
  state_t      w_next_state;
  logic        w_is_jump;
  logic        w_is_illegal;
  logic [3:0]  w_alu_op;
  logic [11:0] w_addr;

  // In DECODE the opcode comes straight off the memory bus; elsewhere from IR.
  assign w_dec_opcode = (r_state == DECODE) ? mem_rdata[15:12] : r_ir[15:12];

  instr_decode u_instr_decode (
    .i_opcode     (w_dec_opcode),
    .o_next_state (w_next_state),
    .o_is_jump    (w_is_jump),
    .o_is_illegal (w_is_illegal),
    .o_alu_op     (w_alu_op)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FETCH;
      r_pc      <= PC_RESET;
      r_ir      <= 16'h0000;
      r_ac      <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (run) r_state <= DECODE;
        end
        DECODE: begin
          r_ir    <= mem_rdata;
          r_pc    <= w_is_jump ? mem_rdata[11:0] : r_pc + 12'd1;
          r_state <= w_next_state;
          if (w_is_illegal) r_illegal <= 1'b1;
        end
        READ: r_state <= EXEC;
        EXEC: begin
          case (r_ir[15:12])
            OP_LOAD:                        r_ac <= mem_rdata;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  r_ac <= alu_result;
            OP_SKIPCOND: begin
              if (skip_taken(r_ir[11:10], r_ac)) r_pc <= r_pc + 12'd1;
            end
            default: ;
          endcase
          r_state <= FETCH;
        end
        WRITE:   r_state <= FETCH;
        HALTED:  r_state <= HALTED;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign w_addr = ((r_state == READ) || (r_state == WRITE)) ? r_ir[11:0] : r_pc;

  assign mem_addr   = {4'b0000, w_addr};
  assign mem_wdata  = r_ac;
  assign mem_we     = (r_state == WRITE);
  assign alu_opcode = (r_state == EXEC) ? w_alu_op : 4'b0000;
  assign alu_a      = r_ac;
  assign alu_b      = mem_rdata;
  assign pc_out     = r_pc;
  assign acc_out    = r_ac;
  assign ir_out     = r_ir;
  assign halted     = (r_state == HALTED);
  assign illegal    = r_illegal;

endmodule
